// File: rtl/spi_txn_arbiter.sv
`timescale 1ns/1ps
// spi_txn_arbiter
// Round-robin scheduler that shares one SPI mode-0 master engine among NREQ
// requesters, one DATA_W-bit transaction at a time. It picks a winner, drives
// the winner's chip select and enforces the CS setup, hold and inter-transaction
// gap times. It starts the engine, waits for completion and returns the received
// byte to the winner.
//
// Ports:
//   clk, rst_n    system clock, asynchronous active-low reset
//   req_valid     per-requester request, held until accepted
//   req_data      per-requester TX byte, slice i = [i*DATA_W +: DATA_W]
//   req_ready     one-hot accept (combinational, IDLE only)
//   rsp_valid     one-hot single-cycle pulse, RX byte for that requester
//   rsp_data      RX byte, valid while any rsp_valid bit is high
//   busy          high whenever the scheduler is not idle
//   eng_start     single-cycle start pulse to the SPI engine
//   eng_tx_data   byte for the engine, stable from eng_start until eng_done
//   eng_done      engine completion pulse
//   eng_rx_data   engine received byte, valid with eng_done
//   cs_n          active-low chip selects, at most one low at a time
module spi_txn_arbiter #(
  parameter int NREQ     = 4,
  parameter int DATA_W   = 8,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int GAP      = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*DATA_W-1:0] req_data,
  output logic [NREQ-1:0]        req_ready,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]      rsp_data,
  output logic                   busy,
  output logic                   eng_start,
  output logic [DATA_W-1:0]      eng_tx_data,
  input  logic                   eng_done,
  input  logic [DATA_W-1:0]      eng_rx_data,
  output logic [NREQ-1:0]        cs_n
);

  localparam int IDX_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int MAX_A   = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int MAX_CNT = (MAX_A > GAP) ? MAX_A : GAP;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_XFER,
    ST_WAIT,
    ST_HOLD,
    ST_GAP
  } state_t;

  state_t            state, next_state;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  grant;
  logic [IDX_W-1:0]  winner;
  logic [IDX_W:0]    cand;
  logic              found;
  logic              accept;
  logic              done_ok;
  logic [IDX_W-1:0]  cs_sel;
  logic [NREQ-1:0]   cs_n_next;

  // Round-robin search: first requesting index at or above ptr, wrapping
  // around. cand carries one extra bit so the wrap subtraction cannot overflow.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NREQ)) begin
        cand = cand - (IDX_W+1)'(NREQ);
      end
      if (!found && req_valid[cand[IDX_W-1:0]]) begin
        found  = 1'b1;
        winner = cand[IDX_W-1:0];
      end
    end
  end

  assign accept  = (state == ST_IDLE) && found;
  assign done_ok = (state == ST_WAIT) && eng_done;

  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready = NREQ'(1) << winner;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic. Each timed phase loads cnt with its length minus one on
  // entry and leaves when cnt reaches zero, so the phase lasts exactly its
  // length in cycles. eng_done is only looked at in WAIT.
  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    case (state)
      ST_IDLE: begin
        if (found) begin
          next_state = ST_SETUP;
          cnt_next   = CNT_W'(CS_SETUP - 1);
        end
      end
      ST_SETUP: begin
        if (cnt == '0) begin
          next_state = ST_XFER;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      ST_XFER: begin
        next_state = ST_WAIT;
      end
      ST_WAIT: begin
        if (eng_done) begin
          next_state = ST_HOLD;
          cnt_next   = CNT_W'(CS_HOLD - 1);
        end
      end
      ST_HOLD: begin
        if (cnt == '0) begin
          next_state = ST_GAP;
          cnt_next   = CNT_W'(GAP - 1);
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt == '0) begin
          next_state = ST_IDLE;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      default: begin
        next_state = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Chip select follows the state being entered so cs_n is a clean register.
  // On acceptance the grant register is not yet loaded, so use the winner.
  always_comb begin
    cs_sel    = accept ? winner : grant;
    cs_n_next = '1;
    if (next_state == ST_SETUP || next_state == ST_XFER ||
        next_state == ST_WAIT  || next_state == ST_HOLD) begin
      cs_n_next = ~(NREQ'(1) << cs_sel);
    end
  end

  // Registered outputs and datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr         <= '0;
      grant       <= '0;
      cs_n        <= '1;
      eng_start   <= 1'b0;
      rsp_valid   <= '0;
      busy        <= 1'b0;
      eng_tx_data <= '0;
      rsp_data    <= '0;
    end else begin
      cs_n      <= cs_n_next;
      eng_start <= (next_state == ST_XFER);
      busy      <= (next_state != ST_IDLE);
      rsp_valid <= done_ok ? (NREQ'(1) << grant) : '0;
      if (accept) begin
        grant       <= winner;
        ptr         <= (winner == IDX_W'(NREQ - 1)) ? '0 : winner + 1'b1;
        eng_tx_data <= req_data[winner*DATA_W +: DATA_W];
      end
      if (done_ok) begin
        rsp_data <= eng_rx_data;
      end
    end
  end

endmodule

// File: tb/tb_spi_txn_arbiter.sv
`timescale 1ns/1ps
// tb_spi_txn_arbiter
// Self-checking bench for spi_txn_arbiter. The stimulus process pushes the
// expected response (requester index and RX byte) into a scoreboard queue at
// acceptance; a monitor pops and compares whenever rsp_valid fires, and also
// watches the chip-select invariants every cycle. A behavioural engine answers
// each eng_start after eng_lat cycles with eng_tx_data ^ 0x99.
module tb_spi_txn_arbiter;

  localparam int NREQ     = 4;
  localparam int DATA_W   = 8;
  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;
  localparam int GAP      = 4;

  typedef struct {
    int         idx;
    logic [7:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [3:0]  rsp_valid;
  logic [7:0]  rsp_data;
  logic        busy;
  logic        eng_start;
  logic [7:0]  eng_tx_data;
  logic        eng_done;
  logic [7:0]  eng_rx_data;
  logic [3:0]  cs_n;

  logic        eng_done_auto = 1'b0;
  logic        spur_done = 1'b0;
  logic [7:0]  eng_rx_auto = '0;
  int          eng_lat = 1;
  bit          eng_kill = 1'b0;

  int          tests = 0;
  int          fails = 0;
  exp_t        exp_q[$];

  logic [7:0]  req_bytes [4] = '{8'h11, 8'h22, 8'hA5, 8'h44};

  assign req_data    = {req_bytes[3], req_bytes[2], req_bytes[1], req_bytes[0]};
  assign eng_done    = eng_done_auto | spur_done;
  assign eng_rx_data = spur_done ? 8'hEE : eng_rx_auto;

  always #5 clk = ~clk;

  spi_txn_arbiter #(
    .NREQ(NREQ), .DATA_W(DATA_W), .CS_SETUP(CS_SETUP),
    .CS_HOLD(CS_HOLD), .GAP(GAP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_data(rsp_data),
    .busy(busy),
    .eng_start(eng_start),
    .eng_tx_data(eng_tx_data),
    .eng_done(eng_done),
    .eng_rx_data(eng_rx_data),
    .cs_n(cs_n)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] valid);
    req_valid = valid;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushExp(input int idx);
    exp_t e;
    e.idx  = idx;
    e.data = req_bytes[idx] ^ 8'h99;
    exp_q.push_back(e);
  endtask

  task automatic waitReady();
    int n;
    n = 0;
    #1;
    while (req_ready == '0 && n < 100) begin
      tick();
      #1;
      n++;
    end
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (busy && n < 300) begin
      tick();
      n++;
    end
    checkOutput("idle_reached", 32'(busy), 0);
  endtask

  // Returns one cycle after acceptance; the request is withdrawn then.
  task automatic issueReq(input logic [3:0] valid, input int exp_idx, input bit expect_rsp);
    applyStimulus(valid);
    waitReady();
    checkOutput("req_ready", 32'(req_ready), 32'(1) << exp_idx);
    if (expect_rsp) pushExp(exp_idx);
    tick();
    applyStimulus(4'b0000);
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Behavioural SPI engine; eng_kill abandons an in-flight transfer.
  initial begin : engine
    bit killed;
    forever begin
      @(posedge clk);
      #1;
      if (eng_start) begin
        killed = 1'b0;
        for (int c = 0; c < eng_lat; c++) begin
          @(posedge clk);
          #1;
          if (eng_kill) begin
            killed = 1'b1;
            break;
          end
        end
        if (!killed) begin
          eng_done_auto = 1'b1;
          eng_rx_auto   = eng_tx_data ^ 8'h99;
          @(posedge clk);
          #1;
          eng_done_auto = 1'b0;
        end
      end
    end
  end

  // Scoreboard monitor and chip-select invariants.
  initial begin : monitor
    exp_t e;
    int   hi_run;
    hi_run = 100;
    forever begin
      @(posedge clk);
      #2;
      checkOutput("cs_single_low", 32'($countones(~cs_n) <= 1), 1);
      if (cs_n == 4'hF) begin
        hi_run++;
      end else begin
        if (hi_run > 0) checkOutput("cs_gap_len", 32'(hi_run >= GAP), 1);
        hi_run = 0;
      end
      if (rsp_valid != '0) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected_rsp: got rsp_valid=%b data=0x%0h, required none at %0t",
                   rsp_valid, rsp_data, $time);
        end else begin
          e = exp_q.pop_front();
          checkOutput("rsp_valid", 32'(rsp_valid), 32'(1) << e.idx);
          checkOutput("rsp_data", 32'(rsp_data), 32'(e.data));
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int n;

    // Reset values
    tick();
    tick();
    checkOutput("rst_cs_n", 32'(cs_n), 32'hF);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_eng_start", 32'(eng_start), 0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 0);
    checkOutput("rst_eng_tx_data", 32'(eng_tx_data), 0);
    checkOutput("rst_rsp_data", 32'(rsp_data), 0);
    rst_n = 1'b1;
    tick();
    checkOutput("idle_req_ready", 32'(req_ready), 0);

    // Single request from requester 2, engine latency 16
    eng_lat = 16;
    issueReq(4'b0100, 2, 1'b1);
    checkOutput("t1_cs_n_T1", 32'(cs_n), 32'b1011);
    checkOutput("t1_busy_T1", 32'(busy), 1);
    checkOutput("t1_start_T1", 32'(eng_start), 0);
    tick();
    checkOutput("t1_cs_n_T2", 32'(cs_n), 32'b1011);
    checkOutput("t1_start_T2", 32'(eng_start), 0);
    tick();
    checkOutput("t1_start_T3", 32'(eng_start), 1);
    checkOutput("t1_tx_data", 32'(eng_tx_data), 32'hA5);
    n = 0;
    while (rsp_valid == '0 && n < 100) begin
      tick();
      n++;
    end
    checkOutput("t1_rsp_latency", 32'(n), 17);
    waitIdle();

    // Wrap search from ptr 3, then 0 beats 1 from ptr 2
    eng_lat = 2;
    issueReq(4'b0010, 1, 1'b1);
    waitIdle();
    issueReq(4'b0011, 0, 1'b1);
    waitIdle();

    // Strict rotation with everyone requesting
    resetDut();
    eng_lat = 3;
    applyStimulus(4'b1111);
    for (int g = 0; g < 5; g++) begin
      waitReady();
      checkOutput("rot_grant", 32'(req_ready), 32'(1) << (g % 4));
      pushExp(g % 4);
      tick();
    end
    applyStimulus(4'b0000);
    waitIdle();

    // Spurious eng_done in IDLE, SETUP and XFER
    eng_lat = 5;
    spur_done = 1'b1;
    tick();
    spur_done = 1'b0;
    checkOutput("spur_idle_busy", 32'(busy), 0);
    checkOutput("spur_idle_rsp", 32'(rsp_valid), 0);
    issueReq(4'b0010, 1, 1'b1);
    spur_done = 1'b1;
    tick();
    spur_done = 1'b0;
    checkOutput("spur_setup_cs", 32'(cs_n), 32'b1101);
    checkOutput("spur_setup_start", 32'(eng_start), 0);
    tick();
    checkOutput("spur_xfer_start", 32'(eng_start), 1);
    spur_done = 1'b1;
    tick();
    spur_done = 1'b0;
    checkOutput("spur_xfer_rsp", 32'(rsp_valid), 0);
    checkOutput("spur_xfer_busy", 32'(busy), 1);
    checkOutput("spur_xfer_cs", 32'(cs_n), 32'b1101);
    waitIdle();

    // Reset during WAIT drops the transaction
    eng_lat = 30;
    issueReq(4'b1000, 3, 1'b0);
    repeat (4) tick();
    eng_kill = 1'b1;
    rst_n = 1'b0;
    #1;
    checkOutput("wrst_cs_n", 32'(cs_n), 32'hF);
    checkOutput("wrst_busy", 32'(busy), 0);
    checkOutput("wrst_rsp", 32'(rsp_valid), 0);
    checkOutput("wrst_start", 32'(eng_start), 0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    eng_kill = 1'b0;
    eng_lat = 2;
    issueReq(4'b1010, 1, 1'b1);
    waitIdle();

    // Request raised during HOLD waits until D+CS_HOLD+GAP+1
    eng_lat = 1;
    issueReq(4'b0001, 0, 1'b1);
    n = 0;
    while (rsp_valid == '0 && n < 50) begin
      tick();
      n++;
    end
    applyStimulus(4'b0100);
    #1;
    checkOutput("late_ready_D1", 32'(req_ready), 0);
    checkOutput("late_cs_D1", 32'(cs_n), 32'b1110);
    for (int i = 2; i <= 6; i++) begin
      tick();
      #1;
      checkOutput("late_ready_hold_gap", 32'(req_ready), 0);
      checkOutput("late_cs_hold_gap", 32'(cs_n), (i == 2) ? 32'b1110 : 32'hF);
    end
    tick();
    #1;
    checkOutput("late_ready_D7", 32'(req_ready), 32'b0100);
    checkOutput("late_busy_D7", 32'(busy), 0);
    pushExp(2);
    tick();
    applyStimulus(4'b0000);
    waitIdle();

    repeat (5) tick();
    checkOutput("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_txn_arbiter.md
# spi_txn_arbiter

Round-robin scheduler that shares one SPI mode-0 master engine among NREQ requesters, one byte transaction at a time. It arbitrates, asserts the winner's chip select, and enforces CS setup, hold and inter-transaction gap times. It starts the engine, waits for completion and returns the received byte to the winner. It sits between the requester blocks and the SPI engine that generates SCLK/MOSI; the engine never touches chip selects.

## Interface
- NREQ, 4, number of requesters (2..8)
- DATA_W, 8, transaction width in bits
- CS_SETUP, 2, clk cycles cs_n is low before eng_start (>=1)
- CS_HOLD, 2, clk cycles cs_n stays low after eng_done (>=1)
- GAP, 4, clk cycles all cs_n high between transactions (>=1)

- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NREQ  per-requester request; held until accepted
- req_data  in  NREQ*DATA_W  per-requester TX byte; slice i = [i*DATA_W +: DATA_W]
- req_ready  out  NREQ  one-hot accept, combinational, only in IDLE
- rsp_valid  out  NREQ  one-hot, one-cycle pulse, RX byte available to that requester
- rsp_data  out  DATA_W  RX byte; valid when any rsp_valid bit is high
- busy  out  1  high in every state except IDLE
- eng_start  out  1  one-cycle start pulse to the SPI engine
- eng_tx_data  out  DATA_W  byte to shift; stable from eng_start until eng_done
- eng_done  in  1  engine completion pulse
- eng_rx_data  in  DATA_W  received byte; valid while eng_done is high
- cs_n  out  NREQ  active-low chip selects; at most one low at any time

## Operation
- States: IDLE, SETUP, XFER, WAIT, HOLD, GAP.
- IDLE → SETUP when any req_valid is high. The winner is the first set bit of req_valid, searched upward from the priority pointer ptr with wrap. req_ready[winner] = 1 in that cycle only. req_data[winner] is captured into eng_tx_data, the grant index is registered, and ptr ← (winner+1) mod NREQ.
- SETUP: cs_n[grant] = 0 for exactly CS_SETUP cycles, counted by a down-counter, then → XFER.
- XFER: one cycle. eng_start = 1, then → WAIT.
- WAIT: hold until eng_done is sampled high. rx_data ← eng_rx_data. → HOLD.
- HOLD: first cycle drives rsp_valid[grant] = 1 and rsp_data = captured byte. cs_n[grant] stays low for CS_HOLD cycles, then → GAP.
- GAP: all cs_n high for GAP cycles, then → IDLE. Requests arriving during GAP wait.
- eng_done outside WAIT is ignored. eng_done in the XFER cycle is ignored.
- req_valid deasserting without acceptance is legal and is not a grant.
- Requesters not granted keep req_valid asserted. Fairness: after requester i is served it is lowest priority. With all requesters requesting, the grant order is strict rotation.
- Reset (asynchronous, any state, including mid-WAIT):
  - state = IDLE, ptr = 0
  - cs_n = all 1s, eng_start = 0, rsp_valid = 0, busy = 0
  - eng_tx_data = 0, rsp_data = 0
  - An in-flight transaction is dropped with no response.

## Timing
- All outputs except req_ready are registered.
- Acceptance at cycle T (IDLE):
  - cs_n[g] low from T+1
  - eng_start high at T+CS_SETUP+1
- eng_done sampled at cycle D:
  - rsp_valid high at D+1
  - cs_n[g] high at D+CS_HOLD+1
  - IDLE at D+CS_HOLD+GAP+1; the next acceptance is possible in that cycle
- Minimum transaction period = CS_SETUP + 3 + CS_HOLD + GAP cycles with zero engine latency; the engine itself takes at least one cycle.
- busy rises at T+1 and falls on IDLE entry.
- cs_n never has two bits low simultaneously. Between two transactions, all cs_n stay high for at least GAP cycles.

## Test plan
- Reset then a single request: req_valid[2] = 1, req_data[2] = 0xA5, engine returns 0x3C after 16 cycles. Required: req_ready[2] at T, cs_n = 4'b1011 from T+1, eng_start at T+3 with eng_tx_data = 0xA5, rsp_valid = 4'b0100 with rsp_data = 0x3C one cycle after eng_done.
- All four requesters continuously valid: grants in order 0,1,2,3,0. Each requester gets exactly one rsp_valid per rotation, and there are 4 GAP cycles with cs_n = 4'hF between consecutive grants.
- ptr = 3 with only req_valid[1] high: requester 1 wins immediately via wrap search. After service, req_valid = 4'b0011 grants 0, not 1.
- Spurious eng_done pulses in IDLE, SETUP and XFER: no state change and no rsp_valid. Only the eng_done in WAIT completes the transaction.
- rst_n low during WAIT: cs_n = 4'hF and busy = 0 immediately, with no rsp_valid. After release, a new request completes normally with ptr = 0 priority.
- Request raised during HOLD and GAP: no req_ready until IDLE. Acceptance occurs exactly at D+CS_HOLD+GAP+1.
